// File: rtl/t_intersection_phase_scheduler.sv
// Demand-actuated phase scheduler for a T-junction (main, main-turn, side + pedestrian).
// Optional build macro EMERGENCY_PREEMPT_EN adds the i_preempt input for emergency pre-emption.
module t_intersection_phase_scheduler #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW    = 2,
    parameter int ALLRED    = 1,
    parameter int CW        = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req_mt,
    input  logic          i_req_s,
    input  logic          i_req_ped,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic          i_preempt,
`endif
    output logic [2:0]    o_light_M1,
    output logic [2:0]    o_light_M2,
    output logic [2:0]    o_light_MT,
    output logic [2:0]    o_light_S,
    output logic          o_walk,
    output logic [2:0]    o_ps,
    output logic [CW-1:0] o_count,
    output logic          o_ack_mt,
    output logic          o_ack_side
);

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        M2_Y   = 3'd1,
        MT_G   = 3'd2,
        MT_Y   = 3'd3,
        MAIN_Y = 3'd4,
        ALL_R  = 3'd5,
        SIDE_G = 3'd6,
        SIDE_Y = 3'd7
    } state_t;

    localparam logic [CW-1:0] MIN_L = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] MAX_L = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] YEL_L = CW'(YELLOW - 1);
    localparam logic [CW-1:0] AR_L  = CW'(ALLRED - 1);

    localparam logic [2:0] LAMP_G = 3'b001;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b100;

    state_t        r_ps;
    state_t        w_ns;
    logic [CW-1:0] r_count;
    logic          r_pendMt;
    logic          r_pendSide;
    logic          r_pendPed;
    logic          r_pedSvc;
    logic          r_lastSide;
    logic          r_ackMt;
    logic          r_ackSide;
    logic          w_preempt;
    logic          w_reqSide;
    logic          w_change;
    logic          w_enterMt;
    logic          w_enterSide;

`ifdef EMERGENCY_PREEMPT_EN
    assign w_preempt = i_preempt;
`else
    assign w_preempt = 1'b0;
`endif

    assign w_reqSide   = i_req_s | i_req_ped;
    assign w_change    = (w_ns != r_ps);
    assign w_enterMt   = w_change && (w_ns == MT_G);
    assign w_enterSide = w_change && (w_ns == SIDE_G);

    // MT is checked before SIDE in MAIN_G so the turn phase is served first;
    // r_lastSide stops ALL_R from re-entering SIDE_G twice in one main cycle.
    always_comb begin
        w_ns = r_ps;
        case (r_ps)
            MAIN_G: begin
                if (!w_preempt && (r_count >= MIN_L)) begin
                    if (r_pendMt)
                        w_ns = M2_Y;
                    else if (r_pendSide)
                        w_ns = MAIN_Y;
                end
            end
            M2_Y:   if (r_count == YEL_L) w_ns = MT_G;
            MT_G: begin
                if (w_preempt || ((r_count == MIN_L) && !i_req_mt) || (r_count == MAX_L))
                    w_ns = MT_Y;
            end
            MT_Y:   if (r_count == YEL_L) w_ns = ALL_R;
            MAIN_Y: if (r_count == YEL_L) w_ns = ALL_R;
            ALL_R: begin
                if (r_count == AR_L) begin
                    if (w_preempt || r_lastSide)
                        w_ns = MAIN_G;
                    else if (r_pendSide)
                        w_ns = SIDE_G;
                    else
                        w_ns = MAIN_G;
                end
            end
            SIDE_G: begin
                if (w_preempt || ((r_count == MIN_L) && !w_reqSide) || (r_count == MAX_L))
                    w_ns = SIDE_Y;
            end
            SIDE_Y: if (r_count == YEL_L) w_ns = ALL_R;
            default: w_ns = ALL_R;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ps       <= MAIN_G;
            r_count    <= '0;
            r_pendMt   <= 1'b0;
            r_pendSide <= 1'b0;
            r_pendPed  <= 1'b0;
            r_pedSvc   <= 1'b0;
            r_lastSide <= 1'b0;
            r_ackMt    <= 1'b0;
            r_ackSide  <= 1'b0;
        end else begin
            r_ps <= w_ns;

            if (w_change)
                r_count <= '0;
            else if ((r_ps == MAIN_G) && (r_count >= MIN_L))
                r_count <= MIN_L;
            else
                r_count <= r_count + CW'(1);

            // Clearing on phase entry takes priority over a request seen on the same edge.
            if (w_enterMt)
                r_pendMt <= 1'b0;
            else if (i_req_mt && (r_ps != M2_Y) && (r_ps != MT_G))
                r_pendMt <= 1'b1;

            if (w_enterSide) begin
                r_pendSide <= 1'b0;
                r_pendPed  <= 1'b0;
                r_pedSvc   <= r_pendPed;
            end else begin
                if (w_reqSide && (r_ps != SIDE_G))
                    r_pendSide <= 1'b1;
                if (i_req_ped && (r_ps != SIDE_G))
                    r_pendPed <= 1'b1;
                if ((r_ps == SIDE_Y) && w_change)
                    r_pedSvc <= 1'b0;
            end

            if (w_enterSide)
                r_lastSide <= 1'b1;
            else if ((r_ps == MAIN_G) || (r_ps == MT_G))
                r_lastSide <= 1'b0;

            r_ackMt   <= w_enterMt;
            r_ackSide <= w_enterSide;
        end
    end

    always_comb begin
        o_light_M1 = LAMP_R;
        o_light_M2 = LAMP_R;
        o_light_MT = LAMP_R;
        o_light_S  = LAMP_R;
        o_walk     = 1'b0;
        case (r_ps)
            MAIN_G: begin o_light_M1 = LAMP_G; o_light_M2 = LAMP_G; end
            M2_Y:   begin o_light_M1 = LAMP_G; o_light_M2 = LAMP_Y; end
            MT_G:   begin o_light_M1 = LAMP_G; o_light_MT = LAMP_G; end
            MT_Y:   begin o_light_M1 = LAMP_Y; o_light_MT = LAMP_Y; end
            MAIN_Y: begin o_light_M1 = LAMP_Y; o_light_M2 = LAMP_Y; end
            SIDE_G: begin o_light_S  = LAMP_G; o_walk = r_pedSvc; end
            SIDE_Y: o_light_S = LAMP_Y;
            default: ;
        endcase
    end

    assign o_ps       = r_ps;
    assign o_count    = r_count;
    assign o_ack_mt   = r_ackMt;
    assign o_ack_side = r_ackSide;

endmodule

// File: tb/tb_t_intersection_phase_scheduler.sv
// Self-checking bench for t_intersection_phase_scheduler: directed scenarios plus
// randomized requests compared against a phase/time-based reference model.
module tb_t_intersection_phase_scheduler;

    localparam int GMIN = 4;
    localparam int GMAX = 10;
    localparam int YEL  = 2;
    localparam int AR   = 1;
    localparam int CW   = 4;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic          clk = 1'b0;
    logic          rRst = 1'b0;
    logic          rMt = 1'b0;
    logic          rS = 1'b0;
    logic          rPed = 1'b0;
    logic          rPre = 1'b0;
    logic [2:0]    lM1, lM2, lMT, lS;
    logic          walk, ackMt, ackSide;
    logic [2:0]    ps;
    logic [CW-1:0] count;

    int checks = 0;
    int passes = 0;

    // Reference model: phase number, unbounded time-in-phase and the request memory.
    int  mPhase = 0;
    int  mT = 0;
    bit  mPendMt, mPendSide, mPendPed, mPedThis;
    int  mLastGreen = 0;
    logic [11:0] lampTab [8];

    always #5 clk = ~clk;

    t_intersection_phase_scheduler #(
        .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW(YEL), .ALLRED(AR), .CW(CW)
    ) dut (
        .i_clk(clk),
        .i_rst(rRst),
        .i_req_mt(rMt),
        .i_req_s(rS),
        .i_req_ped(rPed),
`ifdef EMERGENCY_PREEMPT_EN
        .i_preempt(rPre),
`endif
        .o_light_M1(lM1),
        .o_light_M2(lM2),
        .o_light_MT(lMT),
        .o_light_S(lS),
        .o_walk(walk),
        .o_ps(ps),
        .o_count(count),
        .o_ack_mt(ackMt),
        .o_ack_side(ackSide)
    );

    task automatic modelStep(input bit mt, input bit s, input bit ped, input bit r, input bit pre);
        int  nxt;
        bit  reqSide;
        bit  tmpDone;
        if (r) begin
            mPhase = 0; mT = 0; mPendMt = 0; mPendSide = 0; mPendPed = 0;
            mPedThis = 0; mLastGreen = 0;
        end else begin
            reqSide = s | ped;
            nxt = mPhase;
            tmpDone = (mPhase == 5) ? (mT == AR - 1) : (mT == YEL - 1);
            case (mPhase)
                0: if (!pre && mT >= GMIN - 1) nxt = mPendMt ? 1 : (mPendSide ? 4 : 0);
                1: if (tmpDone) nxt = 2;
                2: if (pre || (mT == GMIN - 1 && !mt) || mT == GMAX - 1) nxt = 3;
                3, 4, 7: if (tmpDone) nxt = 5;
                5: if (tmpDone) nxt = (pre || mLastGreen == 6) ? 0 : (mPendSide ? 6 : 0);
                6: if (pre || (mT == GMIN - 1 && !reqSide) || mT == GMAX - 1) nxt = 7;
                default: nxt = 5;
            endcase
            if (nxt == 2 && mPhase != 2) mPendMt = 0;
            else if (mt && mPhase != 1 && mPhase != 2) mPendMt = 1;
            if (nxt == 6 && mPhase != 6) begin
                mPedThis = mPendPed; mPendSide = 0; mPendPed = 0;
            end else begin
                if (reqSide && mPhase != 6) mPendSide = 1;
                if (ped && mPhase != 6) mPendPed = 1;
            end
            if (nxt != mPhase && (nxt == 0 || nxt == 2 || nxt == 6)) mLastGreen = nxt;
            mT = (nxt != mPhase) ? 0 : mT + 1;
            mPhase = nxt;
        end
    endtask

    task automatic applyStimulus(input bit mt, input bit s, input bit ped, input bit r, input bit pre);
        rMt = mt; rS = s; rPed = ped; rRst = r; rPre = pre;
        @(posedge clk);
        modelStep(mt, s, ped, r, pre);
        #1;
    endtask

    function automatic logic [21:0] expVec();
        int c;
        c = (mPhase == 0 && mT > GMIN - 1) ? GMIN - 1 : mT;
        return {3'(mPhase), 4'(c), lampTab[mPhase], (mPhase == 6) && mPedThis,
                (mPhase == 2) && (mT == 0), (mPhase == 6) && (mT == 0)};
    endfunction

    function automatic logic [21:0] obsVec();
        return {ps, count, lM1, lM2, lMT, lS, walk, ackMt, ackSide};
    endfunction

    task automatic settle();
        int n;
        n = 0;
        while (!(mPhase == 0 && mT >= GMIN - 1 && !mPendMt && !mPendSide && !mPendPed) && n < 100) begin
            applyStimulus(0, 0, 0, 0, 0);
            n++;
        end
        checks++;
        if (n >= 100) $display("[TB] FAIL settle: timeout after %0d cycles, model phase %0d", n, mPhase);
        else passes++;
    endtask

    task automatic test_reset();
        logic [21:0] obs;
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        obs = obsVec();
        checks++;
        if (obs !== {3'd0, 4'd0, G, G, R, R, 1'b0, 2'b00})
            $display("[TB] FAIL reset: got %h required %h", obs, {3'd0, 4'd0, G, G, R, R, 1'b0, 2'b00});
        else passes++;
    endtask

    task automatic test_idle();
        logic [21:0] obs, exp;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            obs = obsVec(); exp = expVec();
            checks++;
            if (obs !== exp) $display("[TB] FAIL idle cyc %0d: got %h required %h", i, obs, exp);
            else passes++;
        end
        checks++;
        if (count !== 4'd3 || ps !== 3'd0) $display("[TB] FAIL idle_sat: got ps %0d count %0d required 0/3", ps, count);
        else passes++;
    endtask

    task automatic test_mt_single();
        logic [21:0] obs, exp;
        logic [2:0]  want [11];
        int          acks;
        want = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd5, 3'd0};
        acks = 0;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(i == 0, 0, 0, 0, 0);
            obs = obsVec(); exp = expVec();
            checks++;
            if (obs !== exp || ps !== want[i])
                $display("[TB] FAIL mt_single cyc %0d: got %h required %h (ps want %0d)", i, obs, exp, want[i]);
            else passes++;
            if (ackMt === 1'b1) acks++;
        end
        checks++;
        if (acks != 1) $display("[TB] FAIL mt_ack_pulses: got %0d required 1", acks);
        else passes++;
    endtask

    task automatic test_side_hold();
        logic [21:0] obs, exp;
        logic [2:0]  tr [$];
        int          k, run;
        settle();
        for (int i = 0; i < 30; i++) begin
            applyStimulus(0, i < 22, 0, 0, 0);
            obs = obsVec(); exp = expVec();
            checks++;
            if (obs !== exp) $display("[TB] FAIL side_hold cyc %0d: got %h required %h", i, obs, exp);
            else passes++;
            tr.push_back(ps);
        end
        k = 0;
        while (k < tr.size() && tr[k] != 3'd6) k++;
        run = 0;
        while (k < tr.size() && tr[k] == 3'd6) begin run++; k++; end
        checks++;
        if (run != GMAX) $display("[TB] FAIL side_len: got %0d required %0d", run, GMAX);
        else passes++;
        while (k < tr.size() && tr[k] == 3'd7) k++;
        while (k < tr.size() && tr[k] == 3'd5) k++;
        checks++;
        if (k >= tr.size() || tr[k] !== 3'd0) $display("[TB] FAIL side_no_repeat: got index %0d required ps 0 after ALL_R", k);
        else passes++;
    endtask

    task automatic test_mt_ped();
        logic [21:0] obs, exp;
        int firstMt, firstSide, walkSeen;
        logic [2:0] prev;
        settle();
        firstMt = -1; firstSide = -1; walkSeen = 0; prev = 3'd0;
        for (int i = 0; i < 36; i++) begin
            applyStimulus(i == 0, 0, i == 0, 0, 0);
            obs = obsVec(); exp = expVec();
            checks++;
            if (obs !== exp) $display("[TB] FAIL mt_ped cyc %0d: got %h required %h", i, obs, exp);
            else passes++;
            if (ps == 3'd2 && firstMt < 0) firstMt = i;
            if (ps == 3'd6 && firstSide < 0) begin
                firstSide = i;
                checks++;
                if (prev !== 3'd5) $display("[TB] FAIL mt_ped_pre_side: got ps %0d required 5", prev);
                else passes++;
            end
            if (walk === 1'b1) walkSeen++;
            prev = ps;
        end
        checks++;
        if (firstMt < 0 || firstSide <= firstMt)
            $display("[TB] FAIL mt_ped_order: got mt %0d side %0d required mt before side", firstMt, firstSide);
        else passes++;
        checks++;
        if (walkSeen != GMIN) $display("[TB] FAIL mt_ped_walk: got %0d walk cycles required %0d", walkSeen, GMIN);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [21:0] obs;
        int n;
        settle();
        applyStimulus(0, 0, 1, 0, 0);
        n = 0;
        while (!(mPhase == 6 && mT == 2) && n < 40) begin
            applyStimulus(0, 0, 0, 0, 0);
            n++;
        end
        checks++;
        if (n >= 40 || walk !== 1'b1 || ps !== 3'd6 || count !== 4'd2)
            $display("[TB] FAIL reset_mid_reach: got ps %0d count %0d walk %b required 6/2/1", ps, count, walk);
        else passes++;
        applyStimulus(0, 0, 0, 1, 0);
        obs = obsVec();
        checks++;
        if (obs !== {3'd0, 4'd0, G, G, R, R, 1'b0, 2'b00})
            $display("[TB] FAIL reset_mid: got %h required %h", obs, {3'd0, 4'd0, G, G, R, R, 1'b0, 2'b00});
        else passes++;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checks++;
            if (ps !== 3'd0 || walk !== 1'b0) $display("[TB] FAIL reset_mid_hold cyc %0d: got ps %0d walk %b required 0/0", i, ps, walk);
            else passes++;
        end
    endtask

`ifdef EMERGENCY_PREEMPT_EN
    task automatic test_preempt();
        logic [21:0] obs, exp;
        logic [2:0]  want [4];
        int n, mtAgain;
        want = '{3'd3, 3'd3, 3'd5, 3'd0};
        settle();
        applyStimulus(1, 0, 0, 0, 0);
        n = 0;
        while (!(mPhase == 2 && mT == 1) && n < 20) begin
            applyStimulus(0, 0, 0, 0, 0);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(i == 5, i == 6, 0, 0, 1);
            obs = obsVec(); exp = expVec();
            checks++;
            if (obs !== exp || ps !== ((i < 4) ? want[i] : 3'd0))
                $display("[TB] FAIL preempt cyc %0d: got %h required %h", i, obs, exp);
            else passes++;
        end
        mtAgain = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            obs = obsVec(); exp = expVec();
            checks++;
            if (obs !== exp) $display("[TB] FAIL preempt_release cyc %0d: got %h required %h", i, obs, exp);
            else passes++;
            if (ps == 3'd2) mtAgain = 1;
        end
        checks++;
        if (mtAgain != 1) $display("[TB] FAIL preempt_pending: got %0d required 1", mtAgain);
        else passes++;
    endtask
`endif

    task automatic test_random();
        logic [21:0] obs, exp;
        bit pre;
        pre = 0;
        for (int i = 0; i < 1500; i++) begin
`ifdef EMERGENCY_PREEMPT_EN
            if ($urandom_range(0, 39) == 0) pre = !pre;
`endif
            applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 11) == 0, $urandom_range(0, 299) == 0, pre);
            obs = obsVec(); exp = expVec();
            checks++;
            if (obs !== exp) $display("[TB] FAIL random cyc %0d: got %h required %h", i, obs, exp);
            else passes++;
        end
    endtask

    initial begin
        lampTab[0] = {G, G, R, R};
        lampTab[1] = {G, Y, R, R};
        lampTab[2] = {G, R, G, R};
        lampTab[3] = {Y, R, Y, R};
        lampTab[4] = {Y, Y, R, R};
        lampTab[5] = {R, R, R, R};
        lampTab[6] = {R, R, R, G};
        lampTab[7] = {R, R, R, Y};
        test_reset();
        test_idle();
        test_mt_single();
        test_side_hold();
        test_mt_ped();
        test_reset_mid();
`ifdef EMERGENCY_PREEMPT_EN
        test_preempt();
`endif
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
